// File: rtl/bp_be_regfile_mp_if.sv
// Bus bundle for bp_be_regfile_mp: debug config port, pipeline write port,
// per-port read issue/data and the clear-sequencer busy flag.
interface bp_be_regfile_mp_if
  #(parameter int data_width_p = 64
   ,parameter int addr_width_p = 5
   ,parameter int read_ports_p = 2
   );

   logic                                 cfg_w_v_i;
   logic                                 cfg_r_v_i;
   logic [addr_width_p-1:0]              cfg_addr_i;
   logic [data_width_p-1:0]              cfg_data_i;
   logic [data_width_p-1:0]              cfg_data_o;
   logic                                 rd_w_v_i;
   logic [addr_width_p-1:0]              rd_addr_i;
   logic [data_width_p-1:0]              rd_data_i;
   logic [read_ports_p-1:0]              rs_r_v_i;
   logic [read_ports_p*addr_width_p-1:0] rs_addr_i;
   logic [read_ports_p*data_width_p-1:0] rs_data_o;
   logic                                 init_busy_o;

   modport master
     (output cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i
     ,output rd_w_v_i, rd_addr_i, rd_data_i
     ,output rs_r_v_i, rs_addr_i
     ,input  cfg_data_o, rs_data_o, init_busy_o
     );

   modport slave
     (input  cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i
     ,input  rd_w_v_i, rd_addr_i, rd_data_i
     ,input  rs_r_v_i, rs_addr_i
     ,output cfg_data_o, rs_data_o, init_busy_o
     );

endinterface

// File: rtl/bp_be_regfile_mp.sv
// Multi-port register file for the BlackParrot backend (int and FP files).
// Each read port holds its last issued address; writes landing on a port's
// effective address are forwarded. Debug reads/writes share the config port.
// Optional macro BP_BE_REGFILE_INIT_CLEAR_EN compiles in a sequencer that
// zeroes every entry after reset.
module bp_be_regfile_mp
  #(parameter int data_width_p = 64
   ,parameter int addr_width_p = 5
   ,parameter int read_ports_p = 2
   ,parameter int zero_x0_p    = 1
   )
   (input  logic              clk_i
   ,input  logic              reset_n_i
   ,bp_be_regfile_mp_if.slave rf_if
   );

   localparam int unsigned els_lp  = 1 << addr_width_p;
   localparam bit          zero_lp = (zero_x0_p != 0);

   logic [data_width_p-1:0]              mem_q    [els_lp];
   logic [addr_width_p-1:0]              held_q   [read_ports_p];
   logic [addr_width_p-1:0]              eff_addr [read_ports_p];
   logic [read_ports_p*data_width_p-1:0] rs_data_q, rs_data_d;
   logic [data_width_p-1:0]              cfg_data_q, cfg_data_d;

   logic                    ready;
   logic                    clr_we;
   logic [addr_width_p-1:0] clr_addr;

   logic                    w_v;
   logic [addr_width_p-1:0] w_addr;
   logic [data_width_p-1:0] w_data;
   logic                    rd_suppress;

`ifdef BP_BE_REGFILE_INIT_CLEAR_EN
   typedef enum logic {E_CLEAR, E_READY} state_e;

   state_e                  state_q;
   logic [addr_width_p-1:0] cnt_q;
   logic                    busy_q;

   // clear sequencer: walk every entry once after reset, then open for use
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= E_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else if (state_q == E_CLEAR) begin
         cnt_q <= cnt_q + addr_width_p'(1);
         if (cnt_q == '1) begin
            state_q <= E_READY;
            busy_q  <= 1'b0;
         end
      end
   end

   assign ready             = (state_q == E_READY);
   assign clr_we            = reset_n_i & ~ready;
   assign clr_addr          = cnt_q;
   assign rf_if.init_busy_o = busy_q;
`else
   assign ready             = 1'b1;
   assign clr_we            = 1'b0;
   assign clr_addr          = '0;
   assign rf_if.init_busy_o = 1'b0;
`endif

   // write arbitration: debug write beats pipeline write; x0 writes vanish when hardwired
   always_comb begin
      w_addr      = rf_if.cfg_w_v_i ? rf_if.cfg_addr_i : rf_if.rd_addr_i;
      w_data      = rf_if.cfg_w_v_i ? rf_if.cfg_data_i : rf_if.rd_data_i;
      w_v         = ready & (rf_if.cfg_w_v_i | rf_if.rd_w_v_i)
                  & ~(zero_lp & (w_addr == '0));
      rd_suppress = rf_if.cfg_w_v_i | rf_if.cfg_r_v_i;
   end

   // read data selection: hardwired zero, then same-cycle write forward, then array
   always_comb begin
      eff_addr  = held_q;
      rs_data_d = '0;
      for (int unsigned k = 0; k < read_ports_p; k++) begin
         if (rf_if.rs_r_v_i[k])
            eff_addr[k] = rf_if.rs_addr_i[k*addr_width_p +: addr_width_p];
         if (zero_lp && (eff_addr[k] == '0))
            rs_data_d[k*data_width_p +: data_width_p] = '0;
         else if (w_v && (w_addr == eff_addr[k]))
            rs_data_d[k*data_width_p +: data_width_p] = w_data;
         else
            rs_data_d[k*data_width_p +: data_width_p] = mem_q[eff_addr[k]];
      end
      if (zero_lp && (rf_if.cfg_addr_i == '0))
         cfg_data_d = '0;
      else if (w_v && (w_addr == rf_if.cfg_addr_i))
         cfg_data_d = w_data;
      else
         cfg_data_d = mem_q[rf_if.cfg_addr_i];
   end

   // held addresses and registered read outputs (outputs hold on suppressed cycles)
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         for (int unsigned k = 0; k < read_ports_p; k++)
            held_q[k] <= '0;
         rs_data_q  <= '0;
         cfg_data_q <= '0;
      end else if (!ready) begin
         rs_data_q  <= '0;
         cfg_data_q <= '0;
      end else begin
         for (int unsigned k = 0; k < read_ports_p; k++)
            if (rf_if.rs_r_v_i[k])
               held_q[k] <= rf_if.rs_addr_i[k*addr_width_p +: addr_width_p];
         if (!rd_suppress)
            rs_data_q <= rs_data_d;
         if (rf_if.cfg_r_v_i)
            cfg_data_q <= cfg_data_d;
      end
   end

   // storage array: clear writes while sequencing, otherwise the arbitrated write
   always_ff @(posedge clk_i) begin
      if (clr_we)
         mem_q[clr_addr] <= '0;
      else if (reset_n_i && w_v)
         mem_q[w_addr] <= w_data;
   end

   assign rf_if.rs_data_o  = rs_data_q;
   assign rf_if.cfg_data_o = cfg_data_q;

endmodule

// File: tb/tb_bp_be_regfile_mp.sv
// Bench for bp_be_regfile_mp: an integer-style instance (2 ports, x0 = 0)
// and an FP-style instance (3 ports, no hardwired zero) share one stimulus
// stream and are checked each cycle against an array-level reference model.
module tb_bp_be_regfile_mp;

   localparam int W   = 64;
   localparam int A   = 5;
   localparam int ELS = 32;
`ifdef BP_BE_REGFILE_INIT_CLEAR_EN
   localparam int CLR = ELS;
`else
   localparam int CLR = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         cfg_w, cfg_r, rd_w;
   logic [A-1:0] cfg_addr, rd_addr;
   logic [W-1:0] cfg_data, rd_data;
   logic [2:0]   rsv;
   logic [A-1:0] rsa [3];

   bp_be_regfile_mp_if #(.data_width_p(W), .addr_width_p(A), .read_ports_p(2)) bus0();
   bp_be_regfile_mp_if #(.data_width_p(W), .addr_width_p(A), .read_ports_p(3)) bus1();

   assign bus0.cfg_w_v_i  = cfg_w;
   assign bus0.cfg_r_v_i  = cfg_r;
   assign bus0.cfg_addr_i = cfg_addr;
   assign bus0.cfg_data_i = cfg_data;
   assign bus0.rd_w_v_i   = rd_w;
   assign bus0.rd_addr_i  = rd_addr;
   assign bus0.rd_data_i  = rd_data;
   assign bus0.rs_r_v_i   = rsv[1:0];
   assign bus0.rs_addr_i  = {rsa[1], rsa[0]};
   assign bus1.cfg_w_v_i  = cfg_w;
   assign bus1.cfg_r_v_i  = cfg_r;
   assign bus1.cfg_addr_i = cfg_addr;
   assign bus1.cfg_data_i = cfg_data;
   assign bus1.rd_w_v_i   = rd_w;
   assign bus1.rd_addr_i  = rd_addr;
   assign bus1.rd_data_i  = rd_data;
   assign bus1.rs_r_v_i   = rsv;
   assign bus1.rs_addr_i  = {rsa[2], rsa[1], rsa[0]};

   bp_be_regfile_mp #(.data_width_p(W), .addr_width_p(A), .read_ports_p(2), .zero_x0_p(1)) dut0
     (.clk_i(clk), .reset_n_i(rst_n), .rf_if(bus0));
   bp_be_regfile_mp #(.data_width_p(W), .addr_width_p(A), .read_ports_p(3), .zero_x0_p(0)) dut1
     (.clk_i(clk), .reset_n_i(rst_n), .rf_if(bus1));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // reference model: plain arrays of register contents and expected outputs
   int           R_of [2] = '{2, 3};
   bit           Z_of [2] = '{1'b1, 1'b0};
   logic [W-1:0] mm   [2][ELS];
   bit           mk   [2][ELS];
   logic [A-1:0] held [2][3];
   logic [W-1:0] exp_rs [2][3];
   bit           exp_rk [2][3];
   logic [W-1:0] exp_cfg [2];
   bit           exp_ck  [2];
   bit           exp_busy;
   int           clr_left;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rs_of(input int i, input int k);
      if (i == 0) return bus0.rs_data_o[k*W +: W];
      return bus1.rs_data_o[k*W +: W];
   endfunction

   function automatic logic [W-1:0] cfg_of(input int i);
      return (i == 0) ? bus0.cfg_data_o : bus1.cfg_data_o;
   endfunction

   function automatic logic busy_of(input int i);
      return (i == 0) ? bus0.init_busy_o : bus1.init_busy_o;
   endfunction

   task automatic lookup(input int i, input logic [A-1:0] a, output logic [W-1:0] v, output bit kn);
      if (Z_of[i] && a == '0) begin
         v = '0; kn = 1'b1;
      end else begin
         v = mm[i][a]; kn = mk[i][a];
      end
   endtask

   // advance the model by one clock edge using the inputs presented before it
   task automatic model_step();
      logic [A-1:0] wa, ea;
      logic [W-1:0] wd;
      bit           wv;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
               held[i][k] = '0; exp_rs[i][k] = '0; exp_rk[i][k] = 1'b1;
            end
            exp_cfg[i] = '0; exp_ck[i] = 1'b1;
         end
         clr_left = CLR;
         exp_busy = (CLR != 0);
         return;
      end
      if (clr_left > 0) begin
         for (int i = 0; i < 2; i++) begin
            mm[i][ELS-clr_left] = '0; mk[i][ELS-clr_left] = 1'b1;
            for (int k = 0; k < 3; k++) begin
               exp_rs[i][k] = '0; exp_rk[i][k] = 1'b1;
            end
            exp_cfg[i] = '0; exp_ck[i] = 1'b1;
         end
         clr_left--;
         exp_busy = (clr_left > 0);
         return;
      end
      exp_busy = 1'b0;
      wv = cfg_w || rd_w;
      wa = cfg_w ? cfg_addr : rd_addr;
      wd = cfg_w ? cfg_data : rd_data;
      for (int i = 0; i < 2; i++)
         if (wv && !(Z_of[i] && wa == '0)) begin
            mm[i][wa] = wd; mk[i][wa] = 1'b1;
         end
      // reads observe the register contents as they stand after this edge's write
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < R_of[i]; k++) begin
            ea = rsv[k] ? rsa[k] : held[i][k];
            if (rsv[k]) held[i][k] = rsa[k];
            if (!(cfg_w || cfg_r)) lookup(i, ea, exp_rs[i][k], exp_rk[i][k]);
         end
         if (cfg_r) lookup(i, cfg_addr, exp_cfg[i], exp_ck[i]);
      end
   endtask

   // compare process: every falling edge, all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < R_of[i]; k++)
               if (exp_rk[i][k]) chk($sformatf("dut%0d_rs%0d", i, k), rs_of(i, k), exp_rs[i][k]);
            if (exp_ck[i]) chk($sformatf("dut%0d_cfg", i), cfg_of(i), exp_cfg[i]);
            chk($sformatf("dut%0d_busy", i), {63'b0, busy_of(i)}, {63'b0, exp_busy});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle();
      cfg_w = 1'b0; cfg_r = 1'b0; rd_w = 1'b0; rsv = '0;
      cfg_addr = '0; cfg_data = '0; rd_addr = '0; rd_data = '0;
      for (int k = 0; k < 3; k++) rsa[k] = '0;
   endtask

   function automatic logic [A-1:0] ra();
      if ($urandom_range(0, 3) == 0) return A'($urandom_range(0, ELS-1));
      return A'($urandom_range(0, 7));
   endfunction

   task automatic wait_clear(input string nm);
      int n;
      n = 0;
      while (busy_of(0) && n < 100) begin
         cyc();
         n++;
      end
      chk(nm, 64'(n), 64'(CLR));
   endtask

   initial begin
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < ELS; a++) begin
            mm[i][a] = '0; mk[i][a] = 1'b0;
         end
      idle();
      rst_n = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      chk("reset_rs0", rs_of(0, 0), 64'h0);
      chk("reset_cfg", cfg_of(1), 64'h0);
      rst_n = 1'b1;
      wait_clear("clear_len");
`ifdef BP_BE_REGFILE_INIT_CLEAR_EN
      for (int a = 1; a < ELS; a++) begin
         rsv[0] = 1'b1; rsa[0] = A'(a);
         cyc();
         chk("cleared_entry", rs_of(1, 0), 64'h0);
      end
      idle();
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      repeat (10) cyc();
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      wait_clear("clear_len_restart");
`endif

      // fill every register with a recognisable value
      for (int a = 0; a < ELS; a++) begin
         rd_w = 1'b1; rd_addr = A'(a); rd_data = 64'hA5A5_0000_0000_0000 | 64'(a);
         cyc();
      end
      idle();

      // stalled port re-reads its held register
      rsv[0] = 1'b1; rsa[0] = 5'd5;
      cyc();
      idle();
      chk("stall_issue", rs_of(0, 0), 64'hA5A5_0000_0000_0005);
      cyc(); cyc();
      chk("stall_hold", rs_of(0, 0), 64'hA5A5_0000_0000_0005);
      rd_w = 1'b1; rd_addr = 5'd5; rd_data = 64'hDEAD_BEEF;
      cyc();
      idle();
      chk("stall_reread0", rs_of(0, 0), 64'hDEAD_BEEF);
      chk("stall_reread1", rs_of(1, 0), 64'hDEAD_BEEF);

      // one write forwarded to every port
      rd_w = 1'b1; rd_addr = 5'd7; rd_data = 64'h1234;
      rsv = 3'b111; rsa[0] = 5'd7; rsa[1] = 5'd7; rsa[2] = 5'd7;
      cyc();
      idle();
      for (int k = 0; k < 3; k++) chk("fwd_all", rs_of(1, k), 64'h1234);
      chk("fwd_all_int", rs_of(0, 1), 64'h1234);

      // x0: discarded on the int file, real storage on the FP file
      rd_w = 1'b1; rd_addr = 5'd0; rd_data = 64'hFFFF; rsv[0] = 1'b1; rsa[0] = 5'd0;
      cyc();
      idle();
      chk("x0_fwd_zero", rs_of(0, 0), 64'h0);
      chk("x0_fwd_real", rs_of(1, 0), 64'hFFFF);
      rsv[0] = 1'b1; rsa[0] = 5'd0;
      cyc();
      idle();
      chk("x0_read_zero", rs_of(0, 0), 64'h0);
      chk("x0_read_real", rs_of(1, 0), 64'hFFFF);

      // debug write beats pipeline write; port outputs hold while debug is active
      rsv = 3'b111; rsa[0] = 5'd1; rsa[1] = 5'd2; rsa[2] = 5'd4;
      cyc();
      idle();
      cfg_w = 1'b1; cfg_addr = 5'd3; cfg_data = 64'hAA;
      rd_w = 1'b1; rd_addr = 5'd3; rd_data = 64'hBB;
      cyc();
      idle();
      chk("cfg_hold_p0", rs_of(0, 0), 64'hA5A5_0000_0000_0001);
      chk("cfg_hold_p1", rs_of(0, 1), 64'hA5A5_0000_0000_0002);
      cfg_r = 1'b1; cfg_addr = 5'd3;
      cyc();
      idle();
      chk("cfg_prio0", cfg_of(0), 64'hAA);
      chk("cfg_prio1", cfg_of(1), 64'hAA);
      chk("cfg_hold_p2", rs_of(1, 2), 64'hA5A5_0000_0000_0004);
      cfg_r = 1'b1; cfg_addr = 5'd9; rd_w = 1'b1; rd_addr = 5'd9; rd_data = 64'h99;
      cyc();
      idle();
      chk("cfg_fwd", cfg_of(0), 64'h99);

      // reset in the middle of operation
      rsv[0] = 1'b1; rsa[0] = 5'd12;
      cyc();
      idle();
      rst_n = 1'b0;
      cyc();
      chk("midreset_rs", rs_of(1, 0), 64'h0);
      chk("midreset_cfg", cfg_of(0), 64'h0);
      rst_n = 1'b1;
      wait_clear("clear_len_midop");

      // randomized traffic; reads are not issued on debug cycles
      for (int n = 0; n < 1500; n++) begin
         idle();
         case ($urandom_range(0, 9))
            0: begin
               cfg_w = 1'b1; cfg_addr = ra(); cfg_data = {$urandom, $urandom};
               rd_w = 1'($urandom_range(0, 1));
               rd_addr = $urandom_range(0, 1) ? cfg_addr : ra();
               rd_data = {$urandom, $urandom};
            end
            1: begin
               cfg_r = 1'b1; cfg_addr = ra();
               rd_w = 1'($urandom_range(0, 1)); rd_addr = ra(); rd_data = {$urandom, $urandom};
            end
            default: begin
               rd_w = 1'($urandom_range(0, 1)); rd_addr = ra(); rd_data = {$urandom, $urandom};
               for (int k = 0; k < 3; k++) begin
                  rsv[k] = 1'($urandom_range(0, 1)); rsa[k] = ra();
               end
            end
         endcase
         cyc();
      end
      idle();
      cyc();
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bp_be_regfile_mp.md
# bp_be_regfile_mp

Parametrised multi-port synchronous register file for the BlackParrot backend calculator. It serves both the integer file (2 read ports, x0 hardwired to zero) and the FP file (3 read ports for FMA, no hardwired zero). Each read port independently holds its last issued address across stalls, and write-to-read hazards are forwarded. Debug access is multiplexed in through the config-bus port. An optional reset-clear sequencer zeroes the array after reset.

## Interface
- data_width_p, 64, register width in bits
- addr_width_p, 5, register address width; els = 2**addr_width_p
- read_ports_p, 2, number of read ports R (1..4)
- zero_x0_p, 1, 1 = address 0 reads as zero and ignores writes
- clk_i  in  1  clock; all state updates on the rising edge
- reset_n_i  in  1  synchronous, active-low reset
- cfg_w_v_i  in  1  debug write strobe
- cfg_r_v_i  in  1  debug read strobe
- cfg_addr_i  in  addr_width_p  debug address
- cfg_data_i  in  data_width_p  debug write data
- cfg_data_o  out  data_width_p  debug read data, valid the cycle after cfg_r_v_i
- rd_w_v_i  in  1  pipeline write strobe
- rd_addr_i  in  addr_width_p  pipeline write address
- rd_data_i  in  data_width_p  pipeline write data
- rs_r_v_i  in  R  per-port issue strobe; captures a new address
- rs_addr_i  in  R*addr_width_p  per-port read address; port k at bits [k*A +: A]
- rs_data_o  out  R*data_width_p  per-port read data; port k at bits [k*W +: W]
- init_busy_o  out  1  high while the clear sequencer runs

## Operation
Effective write:
- If cfg_w_v_i: write cfg_addr_i / cfg_data_i. Any rd write in the same cycle is dropped.
- Otherwise, if rd_w_v_i: write rd_addr_i / rd_data_i.
- With zero_x0_p=1, writes to address 0 are discarded.

Read address per port k:
- eff_addr_k = rs_r_v_i[k] ? rs_addr_i[k] : held_addr_k.
- held_addr_k loads rs_addr_i[k] only when rs_r_v_i[k] is high. Ports are independent.
- The array is re-read at eff_addr_k every cycle. A stalled port therefore sees later writes to its held register.

Forwarding:
- fwd_k = write_v & (write_addr == eff_addr_k).
- On a forward, the array read for port k is suppressed. The write data is registered and driven on rs_data_o[k] the next cycle.

Zero register:
- With zero_x0_p=1, a read of eff_addr_k == 0 returns 0. The forwarding path is not used for address 0.

Config read:
- While cfg_r_v_i or cfg_w_v_i is high, all port reads are suppressed.
- When cfg_r_v_i is high, port 0's array read uses cfg_addr_i. cfg_data_o carries the result next cycle; forwarding still applies.
- rs_data_o holds its previous value on suppressed cycles.

Clear sequencer states:
- CLEAR: entered on reset. Writes 0 to entry cnt, then cnt++. After entry els-1, moves to READY.
- READY: normal operation.

During CLEAR:
- rd, cfg and port reads are ignored.
- rs_data_o = 0, cfg_data_o = 0, init_busy_o = 1.

## Timing
- Read latency is 1 cycle: address at edge N, data after edge N+1.
- Write takes effect at the edge. A same-cycle read of the same address gets the new data via forwarding.
- Reset values:
  - held_addr_k = 0
  - forwarding flags = 0
  - rs_data_o = 0 and cfg_data_o = 0 until the first non-suppressed read completes
  - init_busy_o = 1 (macro on) or 0 (macro off)
- Clear duration: exactly els cycles after reset_n_i rises (32 for A=5). init_busy_o falls in the cycle the first READY operation is accepted.
- Reset asserted mid-clear or mid-operation: counter returns to 0, state to CLEAR, held addresses to 0. No partial-state carry-over.
- Simultaneous rd and cfg write to the same address: cfg data is stored and forwarded.
- All R ports reading the same address as the write: every port forwards.

## Configuration
- Macro: BP_BE_REGFILE_INIT_CLEAR_EN.
- Defined: CLEAR/READY sequencer and counter are compiled in. Every entry reads 0 after reset.
- Undefined: no sequencer, and init_busy_o is tied 0. The file is usable the first cycle after reset. Contents are undefined except address 0 when zero_x0_p=1. Benches must write before reading.

## Test plan
- Reset clear (macro on): release reset, hold reads → init_busy_o high for 32 cycles. Then reads of x1..x31 return 0.
- Stall reread: issue rs_addr port0=5, drop rs_r_v_i, write x5=0xDEAD_BEEF two cycles later → port0 shows 0xDEAD_BEEF one cycle after the write, without re-issue.
- Forward all ports (R=3, zero_x0_p=0): same-cycle write x7=0x1234 and issue x7 on all ports → every port returns 0x1234 next cycle.
- x0 handling: zero_x0_p=1, write x0=0xFFFF, read x0 → returns 0. zero_x0_p=0 → returns 0xFFFF.
- Cfg priority: cfg write x3=0xAA while rd write x3=0xBB, then cfg read x3 → cfg_data_o=0xAA. rd write is dropped; port outputs hold their previous values.
- Reset mid-clear: drop reset_n_i at clear cycle 10 → init_busy_o stays high a full 32 cycles after re-release.
